// File: rtl/victim_cache_pkg.sv
// Shared definitions for the victim cache control slice.
//   vc_state_e : controller FSM states (probe path and evict path)
//   way_w()    : width of a way index for a given number of ways
package victim_cache_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOOKUP = 4'd1,
        LWAIT  = 4'd2,
        READ   = 4'd3,
        RWAIT  = 4'd4,
        CLEAR  = 4'd5,
        RESP   = 4'd6,
        VREAD  = 4'd7,
        VWAIT  = 4'd8,
        WB     = 4'd9,
        WRITE  = 4'd10,
        DSET   = 4'd11
    } vc_state_e;

    // A one-way store still needs a 1-bit index so port widths never collapse to zero.
    function automatic int way_w(input int num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

endpackage

// File: rtl/victim_select.sv
// Replacement-way selection for the victim cache.
//   clk, rst          : clock, synchronous active-high reset
//   valid_shadow      : per-way valid copy held by the controller
//   advance           : step the round-robin pointer (eviction of a valid line accepted)
//   victim_way        : lowest-index invalid way, else the round-robin pointer
//   victim_was_valid  : high when every way is valid and victim_way is the pointer
module victim_select
    import victim_cache_pkg::*;
#(
    parameter  int NUM_WAYS = 4,
    localparam int WAY_W    = way_w(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_WAYS-1:0] valid_shadow,
    input  logic                advance,
    output logic [WAY_W-1:0]    victim_way,
    output logic                victim_was_valid
);

    logic [WAY_W-1:0] rr_ptr;

    // NUM_WAYS is a power of two, so the natural WAY_W-bit wrap gives mod NUM_WAYS.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= rr_ptr + WAY_W'(1);
        end
    end

    // Scan from the top down so the lowest invalid index is the last assignment to land.
    // NOTE: both outputs get a default before the loop; without it this block infers latches.
    always_comb begin
        victim_way       = rr_ptr;
        victim_was_valid = 1'b1;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!valid_shadow[i]) begin
                victim_way       = WAY_W'(i);
                victim_was_valid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/victim_cache_ctrl.sv
// Victim cache controller sitting directly upstream of tag_store.
// Serialises L1 probes (miss lookups) and L1 eviction inserts into single-cycle
// tag_store strobes, picks the replacement way and drives dirty-victim writebacks.
// One transaction in flight at a time.
//   probe_*         : L1 probe request (valid/ready) and one-cycle response pulse
//   evict_*         : L1 eviction insert request (valid/ready)
//   wb_*            : dirty victim writeback to memory (valid/ready)
//   ts_* outputs    : tag_store strobes, tag and way select (0 when no strobe)
//   ts_* inputs     : registered tag_store results, usable the cycle after a strobe
module victim_cache_ctrl
    import victim_cache_pkg::*;
#(
    parameter  int TAG_WIDTH = 4,
    parameter  int NUM_WAYS  = 4,
    localparam int WAY_W     = way_w(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 rst,
    // L1 probe
    input  logic                 probe_valid,
    output logic                 probe_ready,
    input  logic [TAG_WIDTH-1:0] probe_tag,
    output logic                 probe_resp_valid,
    output logic                 probe_hit,
    output logic [WAY_W-1:0]     probe_way,
    output logic                 probe_dirty,
    // L1 eviction insert
    input  logic                 evict_valid,
    output logic                 evict_ready,
    input  logic [TAG_WIDTH-1:0] evict_tag,
    input  logic                 evict_dirty,
    // memory writeback
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [TAG_WIDTH-1:0] wb_tag,
    output logic [WAY_W-1:0]     wb_way,
    // tag_store strobes
    output logic                 ts_write_en,
    output logic                 ts_read_en,
    output logic                 ts_lookup_en,
    output logic                 ts_valid_clear,
    output logic                 ts_dirty_set,
    output logic                 ts_dirty_clear,
    output logic [TAG_WIDTH-1:0] ts_tag_in,
    output logic [WAY_W-1:0]     ts_way_index,
    // tag_store results
    input  logic                 ts_hit,
    input  logic [WAY_W-1:0]     ts_hit_way,
    input  logic                 ts_valid_read,
    input  logic                 ts_dirty_read,
    input  logic [TAG_WIDTH-1:0] ts_tag_read
);

    vc_state_e            state;
    logic [NUM_WAYS-1:0]  valid_shadow;
    logic [TAG_WIDTH-1:0] req_tag_q;      // probe or evict tag; only one is ever in flight
    logic                 evict_dirty_q;
    logic [WAY_W-1:0]     way_q;          // hit way (probe) or victim way (evict)
    logic                 hit_q;
    logic                 dirty_q;
    logic [TAG_WIDTH-1:0] wb_tag_q;

    logic [WAY_W-1:0]     victim_way;
    logic                 victim_was_valid;
    logic                 probe_accept;
    logic                 evict_accept;

    // Probe has priority in IDLE, so an evict is only taken when no probe is offered.
    assign probe_accept = (state == IDLE) && probe_valid;
    assign evict_accept = (state == IDLE) && !probe_valid && evict_valid;

    victim_select #(
        .NUM_WAYS (NUM_WAYS)
    ) u_victim_select (
        .clk              (clk),
        .rst              (rst),
        .valid_shadow     (valid_shadow),
        .advance          (evict_accept && victim_was_valid),
        .victim_way       (victim_way),
        .victim_was_valid (victim_was_valid)
    );

    // NOTE: every register here is assigned with <= so all updates land together at the edge.
    // The shadow mirrors tag_store's valid bits; both reset together, so clearing it on rst
    // keeps the two consistent even when a transaction is aborted mid-flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            valid_shadow  <= '0;
            req_tag_q     <= '0;
            evict_dirty_q <= 1'b0;
            way_q         <= '0;
            hit_q         <= 1'b0;
            dirty_q       <= 1'b0;
            wb_tag_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (probe_accept) begin
                        req_tag_q <= probe_tag;
                        state     <= LOOKUP;
                    end else if (evict_accept) begin
                        req_tag_q     <= evict_tag;
                        evict_dirty_q <= evict_dirty;
                        way_q         <= victim_way;
                        state         <= victim_was_valid ? VREAD : WRITE;
                    end
                end
                LOOKUP: state <= LWAIT;
                LWAIT: begin
                    hit_q   <= ts_hit;
                    dirty_q <= 1'b0;
                    way_q   <= ts_hit ? ts_hit_way : '0;
                    state   <= ts_hit ? READ : RESP;
                end
                READ:  state <= RWAIT;
                RWAIT: begin
                    dirty_q <= ts_dirty_read;
                    state   <= CLEAR;
                end
                // The hit line migrates back to L1, so the victim entry is dropped.
                CLEAR: begin
                    valid_shadow[way_q] <= 1'b0;
                    state               <= RESP;
                end
                RESP:  state <= IDLE;
                VREAD: state <= VWAIT;
                VWAIT: begin
                    if (ts_valid_read && ts_dirty_read) begin
                        wb_tag_q <= ts_tag_read;
                        state    <= WB;
                    end else begin
                        state <= WRITE;
                    end
                end
                WB: begin
                    if (wb_ready) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    valid_shadow[way_q] <= 1'b1;
                    state               <= evict_dirty_q ? DSET : IDLE;
                end
                DSET:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Moore outputs: each strobe is a pure function of state, so each lasts exactly one cycle
    // and at most one is ever active.
    always_comb begin
        probe_ready      = 1'b0;
        evict_ready      = 1'b0;
        probe_resp_valid = 1'b0;
        probe_hit        = 1'b0;
        probe_way        = '0;
        probe_dirty      = 1'b0;
        wb_valid         = 1'b0;
        wb_tag           = '0;
        wb_way           = '0;
        ts_write_en      = 1'b0;
        ts_read_en       = 1'b0;
        ts_lookup_en     = 1'b0;
        ts_valid_clear   = 1'b0;
        ts_dirty_set     = 1'b0;
        ts_tag_in        = '0;
        ts_way_index     = '0;
        case (state)
            IDLE: begin
                probe_ready = 1'b1;
                evict_ready = !probe_valid;
            end
            LOOKUP: begin
                ts_lookup_en = 1'b1;
                ts_tag_in    = req_tag_q;
            end
            READ, VREAD: begin
                ts_read_en   = 1'b1;
                ts_way_index = way_q;
            end
            CLEAR: begin
                ts_valid_clear = 1'b1;
                ts_way_index   = way_q;
            end
            RESP: begin
                probe_resp_valid = 1'b1;
                probe_hit        = hit_q;
                probe_way        = way_q;
                probe_dirty      = dirty_q;
            end
            WB: begin
                wb_valid = 1'b1;
                wb_tag   = wb_tag_q;
                wb_way   = way_q;
            end
            WRITE: begin
                ts_write_en  = 1'b1;
                ts_tag_in    = req_tag_q;
                ts_way_index = way_q;
            end
            DSET: begin
                ts_dirty_set = 1'b1;
                ts_way_index = way_q;
            end
            default: begin
            end
        endcase
    end

    // Reserved strobe: the controller never clears a dirty bit on its own.
    assign ts_dirty_clear = 1'b0;

endmodule
